// File: rtl/wb_regfile.sv
// wb_regfile
//   Write-back end of the three-stage pipeline: commits stage-3 results into a
//   32-entry register file and serves two combinational read ports with
//   same-cycle write-through bypass. A per-register pending-write scoreboard
//   raises a stall for the issue stage while a source operand is in flight.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   wb_data/sel/we     write-back result, destination index, enable
//   rs1, rs2           decode-stage source indices
//   rd1, rd2           combinational read data (index 0 reads 0)
//   iss_valid/ws/we    issuing instruction: valid, destination, writes-reg
//   stall              combinational; issue must hold
//   pend_any           registered; some register has a nonzero pending count
//   sb_err             registered, sticky; write-back with zero pending count
module wb_regfile #(
    parameter int DW  = 32,
    parameter int PCW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wb_data,
    input  logic [4:0]    wb_sel,
    input  logic          wb_we,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          iss_valid,
    input  logic [4:0]    iss_ws,
    input  logic          iss_we,
    output logic          stall,
    output logic          pend_any,
    output logic          sb_err
);

    localparam logic [PCW-1:0] PMAX = '1;
    localparam logic [PCW-1:0] PONE = PCW'(1);

    // Entry 0 is not stored; all lookups below start from zero and only
    // match indices 1..31, so index 0 naturally reads 0 / never pending.
    logic [DW-1:0]  regs     [1:31];
    logic [PCW-1:0] pend     [1:31];
    logic [PCW-1:0] pend_nxt [1:31];

    logic [DW-1:0]  st1, st2;
    logic [PCW-1:0] p1, p2, pw;
    logic           byp1, byp2, bypw;
    logic           blk1, blk2, satw;
    logic           any_nxt, err_nxt;

    // Storage and scoreboard lookups
    always_comb begin
        st1 = '0;
        st2 = '0;
        p1  = '0;
        p2  = '0;
        pw  = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (rs1 == 5'(i)) begin
                st1 = regs[i];
                p1  = pend[i];
            end
            if (rs2 == 5'(i)) begin
                st2 = regs[i];
                p2  = pend[i];
            end
            if (iss_ws == 5'(i)) begin
                pw = pend[i];
            end
        end
    end

    // Read ports with write-through bypass
    always_comb begin
        byp1 = wb_we && (wb_sel == rs1);
        byp2 = wb_we && (wb_sel == rs2);
        bypw = wb_we && (wb_sel == iss_ws);

        if (rs1 == 5'd0)  rd1 = '0;
        else if (byp1)    rd1 = wb_data;
        else              rd1 = st1;

        if (rs2 == 5'd0)  rd2 = '0;
        else if (byp2)    rd2 = wb_data;
        else              rd2 = st2;
    end

    // Hazard detection: a single outstanding write is covered when its
    // write-back is presented this cycle, since the bypass supplies the data.
    always_comb begin
        blk1  = (rs1 != 5'd0) && ((p1 > PONE) || ((p1 == PONE) && !byp1));
        blk2  = (rs2 != 5'd0) && ((p2 > PONE) || ((p2 == PONE) && !byp2));
        satw  = iss_we && (iss_ws != 5'd0) && (pw == PMAX) && !bypw;
        stall = iss_valid && (blk1 || blk2 || satw);
    end

    // Scoreboard next state
    always_comb begin
        err_nxt = sb_err;
        any_nxt = 1'b0;
        for (int unsigned i = 1; i < 32; i++) begin
            logic inc, dec;
            inc = iss_valid && !stall && iss_we && (iss_ws == 5'(i));
            dec = wb_we && (wb_sel == 5'(i));
            pend_nxt[i] = pend[i];
            if (inc && !dec) begin
                if (pend[i] != PMAX) pend_nxt[i] = pend[i] + PONE;
            end else if (dec && !inc) begin
                if (pend[i] == '0) err_nxt     = 1'b1;
                else               pend_nxt[i] = pend[i] - PONE;
            end
            any_nxt = any_nxt | (pend_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            pend_any <= 1'b0;
            sb_err   <= 1'b0;
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                if (wb_we && (wb_sel == 5'(i))) regs[i] <= wb_data;
                pend[i] <= pend_nxt[i];
            end
            pend_any <= any_nxt;
            sb_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
//   Directed-vector self-checking bench for wb_regfile. Inputs change #1 after
//   the rising edge; outputs are sampled mid-cycle, away from the edge.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_data;
    logic [4:0]  wb_sel;
    logic        wb_we;
    logic [4:0]  rs1, rs2;
    logic [31:0] rd1, rd2;
    logic        iss_valid;
    logic [4:0]  iss_ws;
    logic        iss_we;
    logic        stall, pend_any, sb_err;

    int tests  = 0;
    int errors = 0;

    wb_regfile #(.DW(32), .PCW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_data  (wb_data),
        .wb_sel   (wb_sel),
        .wb_we    (wb_we),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd1      (rd1),
        .rd2      (rd2),
        .iss_valid(iss_valid),
        .iss_ws   (iss_ws),
        .iss_we   (iss_we),
        .stall    (stall),
        .pend_any (pend_any),
        .sb_err   (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, then let combinational logic settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        wb_we = 1'b0; wb_sel = '0; wb_data = '0;
        rs1 = '0; rs2 = '0;
        iss_valid = 1'b0; iss_we = 1'b0; iss_ws = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        rs1 = 5'd5;
        settle();
        check("reset_rd1",      rd1,      32'h0);
        check("reset_pend_any", pend_any, 32'h0);
        check("reset_sb_err",   sb_err,   32'h0);
        check("reset_stall",    stall,    32'h0);

        // Write-back to r5: bypass then storage; r0 always reads 0
        wb_we = 1'b1; wb_sel = 5'd5; wb_data = 32'hDEADBEEF; rs1 = 5'd5; rs2 = 5'd0;
        settle();
        check("bypass_rd1", rd1, 32'hDEADBEEF);
        check("bypass_rd2", rd2, 32'h0);
        step();
        wb_we = 1'b0;
        settle();
        check("storage_rd1", rd1, 32'hDEADBEEF);
        check("storage_rd2", rd2, 32'h0);
        // That write-back had nothing pending for r5
        check("wb5_sb_err", sb_err, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("rst_clears_reg", rd1, 32'h0);
        check("rst_clears_err", sb_err, 32'h0);

        // Write-back to r0 is ignored and not a scoreboard error
        wb_we = 1'b1; wb_sel = 5'd0; wb_data = 32'hFFFFFFFF; rs1 = 5'd0;
        settle();
        check("r0_bypass", rd1, 32'h0);
        step();
        wb_we = 1'b0;
        settle();
        check("r0_rd1",      rd1,      32'h0);
        check("r0_pend_any", pend_any, 32'h0);
        check("r0_sb_err",   sb_err,   32'h0);

        // Issue to r7, then a reader of r7 on both ports
        iss_valid = 1'b1; iss_we = 1'b1; iss_ws = 5'd7; rs1 = 5'd0; rs2 = 5'd0;
        settle();
        check("iss7_stall", stall, 32'h0);
        step();
        iss_we = 1'b0; iss_ws = 5'd0; rs1 = 5'd7; rs2 = 5'd7;
        settle();
        check("iss7_pend_any", pend_any, 32'h1);
        check("rd7_stall_a",   stall,    32'h1);
        step();
        settle();
        check("rd7_stall_b",   stall,    32'h1);
        step();
        wb_we = 1'b1; wb_sel = 5'd7; wb_data = 32'h00001234;
        settle();
        check("rd7_release", stall, 32'h0);
        check("rd7_rd1",     rd1,   32'h00001234);
        check("rd7_rd2",     rd2,   32'h00001234);
        step();
        idle_inputs();
        rs1 = 5'd7;
        settle();
        check("rd7_pend_any", pend_any, 32'h0);
        check("rd7_storage",  rd1,      32'h00001234);
        check("rd7_sb_err",   sb_err,   32'h0);

        // Three issues to r3 saturate the counter; fourth stalls
        iss_valid = 1'b1; iss_we = 1'b1; iss_ws = 5'd3; rs1 = 5'd0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("iss3_nostall", stall, 32'h0);
            step();
        end
        settle();
        check("iss3_sat_stall", stall, 32'h1);
        wb_we = 1'b1; wb_sel = 5'd3; wb_data = 32'h33;
        settle();
        check("iss3_sat_wb", stall, 32'h0);
        step();
        // Count must still be 3: reader stalls through two write-backs
        idle_inputs();
        iss_valid = 1'b1; rs1 = 5'd3;
        settle();
        check("r3_cnt3", stall, 32'h1);
        wb_we = 1'b1; wb_sel = 5'd3; wb_data = 32'h31;
        settle();
        check("r3_wb_a", stall, 32'h1);
        step();
        wb_data = 32'h32;
        settle();
        check("r3_wb_b", stall, 32'h1);
        step();
        wb_data = 32'h3F;
        settle();
        check("r3_wb_c",     stall, 32'h0);
        check("r3_wb_c_rd1", rd1,   32'h3F);
        step();
        idle_inputs();
        settle();
        check("r3_pend_any", pend_any, 32'h0);
        check("r3_sb_err",   sb_err,   32'h0);

        // Spurious write-back to r9 sets sticky error
        wb_we = 1'b1; wb_sel = 5'd9; wb_data = 32'h9;
        step();
        wb_we = 1'b0;
        settle();
        check("r9_sb_err", sb_err, 32'h1);
        for (int i = 0; i < 10; i++) step();
        check("r9_sb_err_held", sb_err, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("r9_sb_err_rst", sb_err, 32'h0);

        // Reset with pend[4]=2 and a simultaneous commit to r4
        iss_valid = 1'b1; iss_we = 1'b1; iss_ws = 5'd4;
        step();
        step();
        idle_inputs();
        settle();
        check("r4_pend_any", pend_any, 32'h1);
        rst = 1'b1; wb_we = 1'b1; wb_sel = 5'd4; wb_data = 32'hAAAA5555; rs1 = 5'd4;
        settle();
        check("r4_rst_bypass", rd1, 32'hAAAA5555);
        step();
        rst = 1'b0; wb_we = 1'b0; iss_valid = 1'b1; iss_we = 1'b0; rs1 = 5'd4;
        settle();
        check("r4_rd1",      rd1,      32'h0);
        check("r4_stall",    stall,    32'h0);
        check("r4_pend_any", pend_any, 32'h0);
        check("r4_sb_err",   sb_err,   32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the three-stage pipeline. It consumes the result, write-select and write-enable launched by the stage-3 pipeline register and commits them into a 32-entry general register file. It serves two combinational read ports to the decode stage with same-cycle write-through bypass. A per-register pending-write scoreboard raises a stall for the issue stage while a source operand is still in flight.

## Interface
Parameters:
- `DW`, 32, data width of registers, read ports and write-back data
- `PCW`, 2, width of each per-register pending counter; saturates at 2^PCW-1

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wb_data`  in  DW  write-back result from stage-3 register
- `wb_sel`  in  5  write-back destination register index
- `wb_we`  in  1  write-back enable
- `rs1`, `rs2`  in  5 each  decode-stage source indices
- `rd1`, `rd2`  out  DW each  combinational read data
- `iss_valid`  in  1  decode stage presents an instruction this cycle
- `iss_ws`  in  5  destination of issuing instruction
- `iss_we`  in  1  issuing instruction writes a register
- `stall`  out  1  combinational; issue must hold
- `pend_any`  out  1  registered; some register has a nonzero pending count
- `sb_err`  out  1  registered, sticky; write-back arrived for a register with zero pending count

## Operation
- Storage: `regs[1..31]`, DW bits each. Index 0 is not stored; it reads 0, ignores writes and is never pending.
- Commit: on a clock edge with `wb_we=1` and `wb_sel!=0`, `regs[wb_sel] <= wb_data`.
- Read: `rdN` = 0 if `rsN=0`; else `wb_data` if `wb_we && wb_sel==rsN`; else `regs[rsN]`.
- Scoreboard: `pend[1..31]`, PCW bits each.
  - Increment condition `inc(r)`: `iss_valid && !stall && iss_we && iss_ws==r`.
  - Decrement condition `dec(r)`: `wb_we && wb_sel==r`.
  - If both `inc(r)` and `dec(r)` hold, `pend[r]` is unchanged.
  - `inc` alone at saturation: `pend[r]` stays at max. The stall rule makes this unreachable.
  - `dec` alone with `pend[r]=0`: `pend[r]` stays 0 and `sb_err <= 1`.
- A source is blocked when `rsN!=0` and either:
  - `pend[rsN] >= 2`, or
  - `pend[rsN]==1` and not `(wb_we && wb_sel==rsN)`. The bypass covers the final write in the same cycle.
- Destination is saturated when `iss_we && iss_ws!=0 && pend[iss_ws]==max && !(wb_we && wb_sel==iss_ws)`.
- `stall = iss_valid && (rs1 blocked || rs2 blocked || dest saturated)`.
- Issues with `iss_ws=0` or `iss_we=0` never touch the scoreboard.
- `pend_any` is the OR of the next-state `pend[]` values, registered.

## Timing
- Reset:
  - All `regs`, all `pend`, `pend_any` and `sb_err` are cleared in the cycle `rst` is sampled high.
  - During reset, `rd1`/`rd2` show bypass/storage as usual. They read 0 the cycle after, unless a bypass is active.
  - `stall` stays combinational throughout.
  - Reset wins over a simultaneous commit or scoreboard update.
- Write latency: data committed at edge N is visible from storage in cycle N+1. In cycle N itself it is visible via bypass.
- Read latency is 0: `rd1`/`rd2`/`stall` settle combinationally from current inputs and state.
- Write-read coherence: a register issued at cycle N (`iss_we=1`) stalls any reader until the cycle its write-back is presented. That reader then proceeds with bypassed data.
- Two issues to the same destination: `pend=2`. Readers stall through the first write-back and proceed on the second.
- `sb_err` rises on the edge after the offending write-back and holds until `rst`.

## Test plan
- Reset, then write-back `wb_sel=5`, `wb_data=0xDEADBEEF`, `wb_we=1`:
  - same cycle `rs1=5` -> `rd1=0xDEADBEEF` (bypass);
  - next cycle -> same value from storage;
  - `rs2=0` -> `rd2=0` throughout.
- Write-back to index 0 with `0xFFFFFFFF` -> `rd1=0` when `rs1=0`; no `pend` change; `sb_err` stays 0.
- Issue `iss_ws=7`, then issue a reader with `rs1=7`:
  - `stall=1` for each cycle until `wb_we=1`, `wb_sel=7`, `wb_data=0x1234`;
  - in that cycle `stall=0` and `rd1=0x1234`;
  - afterwards `pend_any=0`.
- Issue to `r3` three times with no write-back -> fourth issue to `r3` sees `stall=1`. A simultaneous write-back to `r3` drops `stall` to 0 and the count stays 3.
- Write-back to `r9` with `pend[9]=0` -> `sb_err=1` the next cycle and held across 10 idle cycles. `rst` clears it.
- Assert `rst` while `pend[4]=2` and a commit to `r4` is in the same cycle -> next cycle `rd1(rs1=4)=0`, `stall=0`, `pend_any=0`.
